// File: rtl/pipe_track_pkg.sv
// rtl/pipe_track_pkg.sv - shared widths and stage indices for the pipeline tracker
package pipe_track_pkg;

  localparam int IW_DEF = 8;
  localparam int AW_DEF = 8;
  localparam int RW_DEF = 2;

  // Stage numbers (1 = youngest) used by the controller to slice st_instr/st_pc
  localparam int STG_DEC = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WBK = 4;

  function automatic int stage_lsb(input int stage, input int width);
    return (stage - 1) * width;
  endfunction

endpackage

// File: rtl/pipe_track_stage.sv
// rtl/pipe_track_stage.sv - one valid-tagged instruction/PC stage register
module pipe_track_stage
  import pipe_track_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          bubble,
  input  logic          kill,
  input  logic          d_valid,
  input  logic [IW-1:0] d_instr,
  input  logic [AW-1:0] d_pc,
  input  logic          d_wr,
  input  logic [RW-1:0] d_rd,
  output logic          q_valid,
  output logic [IW-1:0] q_instr,
  output logic [AW-1:0] q_pc,
  output logic          q_wr,
  output logic [RW-1:0] q_rd
);

  // Kill and bubble only drop the tags; instr/pc/rd hold as don't-care payload
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
      q_wr    <= 1'b0;
      q_rd    <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_wr    <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      q_instr <= d_instr;
      q_pc    <= d_pc;
      q_wr    <= d_wr;
      q_rd    <= d_rd;
    end else if (bubble) begin
      q_valid <= 1'b0;
      q_wr    <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_track.sv
// rtl/pipe_track.sv - in-order pipeline tracker with RAW stall, flush and retire count (option: PIPE_TRACK_WB_BYPASS_EN)
module pipe_track
  import pipe_track_pkg::*;
#(
  parameter int IW           = IW_DEF,
  parameter int AW           = AW_DEF,
  parameter int RW           = RW_DEF,
  parameter int STAGES       = 4,
  parameter int FLUSH_STAGES = 2,
  parameter int CW           = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IW-1:0]        in_instr,
  input  logic [AW-1:0]        in_pc,
  input  logic                 in_wr,
  input  logic [RW-1:0]        in_rd,
  input  logic [RW-1:0]        in_rs1,
  input  logic [RW-1:0]        in_rs2,
  input  logic                 in_use1,
  input  logic                 in_use2,
  input  logic                 flush,
  output logic                 in_ready,
  output logic                 hazard,
  output logic [STAGES-1:0]    st_valid,
  output logic [STAGES*IW-1:0] st_instr,
  output logic [STAGES*AW-1:0] st_pc,
  output logic                 retire,
  output logic [CW-1:0]        retire_cnt
);

`ifdef PIPE_TRACK_WB_BYPASS_EN
  localparam int NCHK = STAGES - 1;
`else
  localparam int NCHK = STAGES;
`endif

  logic [STAGES-1:0]         v, wr, ld, bub, kil, d_v, d_wr;
  logic [STAGES-1:0][IW-1:0] ins, d_ins;
  logic [STAGES-1:0][AW-1:0] pc, d_pc;
  logic [STAGES-1:0][RW-1:0] rd, d_rd;
  logic                      hit, accept;

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NCHK; k++) begin
      if (v[k] && wr[k] &&
          ((in_use1 && rd[k] == in_rs1) || (in_use2 && rd[k] == in_rs2)))
        hit = 1'b1;
    end
  end

  assign hazard   = in_valid & hit;
  assign in_ready = ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign d_v[k]   = 1'b1;
      assign d_ins[k] = in_instr;
      assign d_pc[k]  = in_pc;
      assign d_wr[k]  = in_wr;
      assign d_rd[k]  = in_rd;
      assign ld[k]    = accept;
      assign bub[k]   = ~accept;
    end else begin : g_body
      // Older stages advance unconditionally; there is no back-pressure below stage 1
      assign d_v[k]   = v[k-1];
      assign d_ins[k] = ins[k-1];
      assign d_pc[k]  = pc[k-1];
      assign d_wr[k]  = wr[k-1];
      assign d_rd[k]  = rd[k-1];
      assign ld[k]    = 1'b1;
      assign bub[k]   = 1'b0;
    end
    assign kil[k] = flush & (k < FLUSH_STAGES);

    pipe_track_stage #(.IW(IW), .AW(AW), .RW(RW)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .load    (ld[k]),
      .bubble  (bub[k]),
      .kill    (kil[k]),
      .d_valid (d_v[k]),
      .d_instr (d_ins[k]),
      .d_pc    (d_pc[k]),
      .d_wr    (d_wr[k]),
      .d_rd    (d_rd[k]),
      .q_valid (v[k]),
      .q_instr (ins[k]),
      .q_pc    (pc[k]),
      .q_wr    (wr[k]),
      .q_rd    (rd[k])
    );
  end

  assign st_valid = v;
  assign st_instr = ins;
  assign st_pc    = pc;
  assign retire   = v[STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      retire_cnt <= '0;
    else if (v[STAGES-1])
      retire_cnt <= retire_cnt + CW'(1);
  end

endmodule

// File: tb/tb_pipe_track.sv
// tb/tb_pipe_track.sv - directed self-checking bench for pipe_track
module tb_pipe_track;

`ifdef PIPE_TRACK_WB_BYPASS_EN
  localparam int HZ_CYC = 3;
`else
  localparam int HZ_CYC = 4;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_instr = '0;
  logic [7:0]  in_pc = '0;
  logic        in_wr = 1'b0;
  logic [1:0]  in_rd = '0;
  logic [1:0]  in_rs1 = '0;
  logic [1:0]  in_rs2 = '0;
  logic        in_use1 = 1'b0;
  logic        in_use2 = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready, hazard, retire;
  logic [3:0]  st_valid;
  logic [31:0] st_instr, st_pc;
  logic [3:0]  retire_cnt;

  int checks = 0;
  int errors = 0;

  pipe_track #(.IW(8), .AW(8), .RW(2), .STAGES(4), .FLUSH_STAGES(2), .CW(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_wr(in_wr), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use1(in_use1), .in_use2(in_use2), .flush(flush), .in_ready(in_ready),
    .hazard(hazard), .st_valid(st_valid), .st_instr(st_instr), .st_pc(st_pc),
    .retire(retire), .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ins, input logic [7:0] p,
                       input logic w, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2, input logic u1, input logic u2);
    in_valid = v; in_instr = ins; in_pc = p; in_wr = w; in_rd = d;
    in_rs1 = s1; in_rs2 = s2; in_use1 = u1; in_use2 = u2;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    flush = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (st_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", st_valid); end
    checks++;
    if (retire_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
    checks++;
    if (in_ready !== 1'b1 || hazard !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL reset_flags got rdy=%b hz=%b ret=%b want 1 0 0", in_ready, hazard, retire);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 8'(i), 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick();
      exp = 4'((1 << (i + 1)) - 1);
      checks++;
      if (st_valid !== exp) begin errors++; $display("FAIL fill_valid%0d got %b want %b", i, st_valid, exp); end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (st_pc !== 32'h00010203) begin errors++; $display("FAIL fill_pc got %h want 00010203", st_pc); end
    checks++;
    if (st_instr !== 32'h10111213) begin errors++; $display("FAIL fill_instr got %h want 10111213", st_instr); end
    checks++;
    if (retire !== 1'b1 || retire_cnt !== 4'd0) begin
      errors++; $display("FAIL fill_pre_retire got ret=%b cnt=%0d want 1 0", retire, retire_cnt);
    end
    tick();
    checks++;
    if (retire_cnt !== 4'd1 || st_valid !== 4'b1110) begin
      errors++; $display("FAIL fill_retire got cnt=%0d v=%b want 1 1110", retire_cnt, st_valid);
    end
  endtask

  task automatic test_hazard();
    logic [3:0] exp;
    do_reset();
    drive(1'b1, 8'hAA, 8'h20, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'hBB, 8'h21, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_novalid got hz=%b rdy=%b want 0 1", hazard, in_ready);
    end
    drive(1'b1, 8'hBB, 8'h21, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < HZ_CYC; c++) begin
      checks++;
      if (hazard !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hazard_stall%0d got hz=%b rdy=%b want 1 0", c, hazard, in_ready);
      end
      tick();
      exp = 4'(1 << (c + 1));
      checks++;
      if (st_valid !== exp) begin errors++; $display("FAIL hazard_bubble%0d got %b want %b", c, st_valid, exp); end
    end
    checks++;
    if (hazard !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_release got hz=%b rdy=%b want 0 1", hazard, in_ready);
    end
    tick();
    checks++;
    if (st_valid !== 4'b0001 || st_instr[7:0] !== 8'hBB || st_pc[7:0] !== 8'h21) begin
      errors++; $display("FAIL hazard_accept got v=%b i=%h p=%h want 0001 bb 21", st_valid, st_instr[7:0], st_pc[7:0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 8'(i), 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h34, 8'h04, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || hazard !== 1'b0) begin
      errors++; $display("FAIL flush_ready got rdy=%b hz=%b want 0 0", in_ready, hazard);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (st_valid !== 4'b1100 || st_pc[31:16] !== 16'h0102) begin
      errors++; $display("FAIL flush_kill got v=%b pc43=%h want 1100 0102", st_valid, st_pc[31:16]);
    end
    checks++;
    if (retire_cnt !== 4'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_cnt got cnt=%0d rdy=%b want 1 1", retire_cnt, in_ready);
    end
    tick();
    checks++;
    if (st_valid !== 4'b1001 || st_pc[7:0] !== 8'h04 || st_pc[31:24] !== 8'h02 || retire_cnt !== 4'd2) begin
      errors++; $display("FAIL flush_resume got v=%b p1=%h p4=%h cnt=%0d want 1001 04 02 2",
                         st_valid, st_pc[7:0], st_pc[31:24], retire_cnt);
    end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    drive(1'b1, 8'h40, 8'h40, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h41, 8'h41, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h42, 8'h42, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h43, 8'h43, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flushhz_flags got hz=%b rdy=%b want 1 0", hazard, in_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (st_valid !== 4'b1100 || st_pc[31:16] !== 16'h4041) begin
      errors++; $display("FAIL flushhz_stages got v=%b pc43=%h want 1100 4041", st_valid, st_pc[31:16]);
    end
  endtask

  task automatic test_wrap_reset();
    logic [3:0] exp;
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      drive(1'b1, 8'(t), 8'(t), 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick();
      exp = 4'((t > 4) ? t - 4 : 0);
      checks++;
      if (retire_cnt !== exp) begin errors++; $display("FAIL wrap_cnt_t%0d got %0d want %0d", t, retire_cnt, exp); end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (st_valid !== 4'b0000 || retire_cnt !== 4'd0) begin
      errors++; $display("FAIL async_reset got v=%b cnt=%0d want 0000 0", st_valid, retire_cnt);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hazard();
    test_flush();
    test_flush_hazard();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_track.md
Name: pipe_track

Overview:
- Parametrised in-order pipeline tracking block for the next-generation processor datapath.
- Generalises the fixed IR/IR3/IR4 and PC/PC2/PC3 chains to STAGES stages of valid-tagged instruction/PC registers.
- Adds RAW-hazard stall (bubble insertion), branch flush of younger stages, and a retired-instruction counter.
- Sits between instruction fetch (memory q_pc port) and the controller; the controller decodes each stage's instr output.

Parameters:
- IW, 8, instruction width.
- AW, 8, PC width.
- RW, 2, register-index width (2^RW architectural registers).
- STAGES, 4, pipeline depth after fetch; legal range 2..8.
- FLUSH_STAGES, 2, number of youngest stages killed on flush; legal range 1..STAGES-1.
- CW, 16, retire counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  fetch offers an instruction
- in_instr  in  IW  fetched instruction
- in_pc  in  AW  PC of fetched instruction
- in_wr  in  1  instruction writes register file
- in_rd  in  RW  destination register
- in_rs1  in  RW  source 1 index
- in_rs2  in  RW  source 2 index
- in_use1  in  1  source 1 is read
- in_use2  in  1  source 2 is read
- flush  in  1  branch taken; kill younger stages
- in_ready  out  1  fetch accepted this cycle (fetch must hold PC when 0)
- hazard  out  1  RAW conflict detected
- st_valid  out  STAGES  bit k-1 = stage k valid (stage 1 youngest)
- st_instr  out  STAGES*IW  stage k at bits [k*IW-1:(k-1)*IW]
- st_pc  out  STAGES*AW  same packing
- retire  out  1  = st_valid[STAGES-1]
- retire_cnt  out  CW  instructions retired since reset

Behaviour:
- Reset: all st_valid, st_instr, st_pc, internal wr/rd tags and retire_cnt cleared to 0. in_ready is then 1 and hazard is 0 (combinational, no valid stages).
- Every cycle, stages k=2..STAGES load from stage k-1, including valid, instr, pc, wr and rd. Whatever occupies stage STAGES is overwritten (retired). The pipeline has no back-pressure below stage 1.
- Hazard, combinational: hazard = in_valid & OR over checked stages k of (st_valid[k] & wr[k] & ((in_use1 & rd[k]==in_rs1) | (in_use2 & rd[k]==in_rs2))).
  - Checked stages: 1..STAGES by default; see Optional Feature.
- in_ready = ~hazard & ~flush.
- Stage 1 next state:
  - If in_valid & in_ready: load the input, valid=1.
  - Otherwise: bubble (valid=0, wr=0; instr/pc hold their previous value as don't-care).
- Flush, with priority over advance and input:
  - Next-cycle stages 1..FLUSH_STAGES get valid=0 and wr=0.
  - Stages FLUSH_STAGES+1..STAGES shift normally.
  - The input is not accepted.
- Flush and hazard in the same cycle: flush wins; in_ready=0; hazard still reported.
- Stage STAGES is never killed by flush; it always retires.
- retire_cnt increments by 1 on each edge where st_valid[STAGES-1]=1. It wraps from 2^CW-1 to 0.
- Latency: an accepted instruction is in stage k exactly k cycles after acceptance, absent flush.
- A stalled instruction re-checks every cycle. It is accepted in the cycle after the last conflicting stage has retired.
- Reset asserted mid-operation: everything clears immediately (asynchronous); no partial retire is counted.
- in_valid=0 never raises hazard.

Optional Feature:
- Macro PIPE_TRACK_WB_BYPASS_EN.
- Defined: the register file forwards the write data on a same-cycle read, so stage STAGES is excluded from the hazard check (checked stages 1..STAGES-1). This saves one stall cycle per dependency.
- Undefined: all stages 1..STAGES are checked.

Decomposition:
- Shared package holds the default widths IW_DEF=8, AW_DEF=8, RW_DEF=2 and the stage-index constants used by the controller to slice st_instr/st_pc.
- One sub-module, pipe_track_stage: a single stage register holding valid, instr, pc, wr and rd, with load, bubble and kill inputs. It is instantiated STAGES times via generate.
- Hazard compare and retire counter stay in the top module.

Test Plan (STAGES=4, FLUSH_STAGES=2, macro undefined):
- Reset then 4 independent instructions at pc 0..3, all in_wr=0 -> st_valid goes 0001, 0011, 0111, 1111 over 4 cycles; retire_cnt=1 one cycle after st_valid[3]=1.
- Instruction A (in_wr=1, in_rd=2) then B (in_use1=1, in_rs1=2) -> hazard=1 and in_ready=0 for 4 cycles with bubbles in stage 1; B is accepted on the 5th cycle.
- Same as above with PIPE_TRACK_WB_BYPASS_EN defined -> hazard lasts 3 cycles.
- Pipeline full, flush=1 for one cycle -> next cycle st_valid=1100 with old stages 2,3 now in 3,4; in_ready=0 during flush; the input is re-accepted the next cycle.
- flush and hazard asserted together -> in_ready=0, stage 1 bubble; stages 3,4 advance normally.
- Preload/run with CW=4 until 16 retires -> retire_cnt wraps to 0; asserting reset mid-stream clears st_valid=0000 and retire_cnt=0 asynchronously.
